// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, halt/resume and trap-on-misalign.
// Define PC_RAS_EN to build in the return-address stack.
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             HALT,
  input  logic             RESUME,
  input  logic             BR_TAKE,
  input  logic [WIDTH-1:0] BR_OFF,
  input  logic             JMP_TAKE,
  input  logic [WIDTH-1:0] JMP_TGT,
  input  logic             CALL,
  input  logic             RET,
  output logic [WIDTH-1:0] PC_OUT,
  output logic             PC_VALID,
  output logic             MISALIGN,
  output logic             RAS_EMPTY,
  output logic             RAS_UFLOW
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mis_q, mis_d;
  logic             uflow_q, uflow_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] tgt;
  logic             redir;
  logic             ret_req;
  logic             rs_empty;
  logic [WIDTH-1:0] rs_top;

  assign seq_pc = pc_q + STEP_W;

`ifdef PC_RAS_EN
  localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [AW-1:0]    top_q, top_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             adv, push, pop;

  assign adv      = (state_q == S_RUN) && !HALT && !STALL;
  assign push     = adv && JMP_TAKE && CALL;
  assign pop      = adv && !JMP_TAKE && !BR_TAKE && RET && !rs_empty;
  assign ret_req  = RET;
  assign rs_empty = (cnt_q == '0);
  assign rs_top   = ras_q[top_q];

  // Circular buffer: a push when full silently drops the oldest entry.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    ras_d = ras_q;
    if (push) begin
      top_d        = top_q + 1'b1;
      ras_d[top_d] = seq_pc;
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end
`else
  localparam int unsigned unused_depth = RAS_DEPTH;
  logic unused_ras;

  assign unused_ras = ^{CALL, RET};
  assign ret_req    = 1'b0;
  assign rs_empty   = 1'b1;
  assign rs_top     = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    uflow_d = 1'b0;
    tgt     = seq_pc;
    redir   = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_HALT: if (RESUME) state_d = S_RUN;
      default: begin
        if (HALT) begin
          state_d = S_HALT;
        end else if (!STALL) begin
          if (JMP_TAKE) begin
            tgt   = JMP_TGT;
            redir = 1'b1;
          end else if (BR_TAKE) begin
            tgt   = pc_q + BR_OFF;
            redir = 1'b1;
          end else if (ret_req && !rs_empty) begin
            tgt   = rs_top;
            redir = 1'b1;
          end else if (ret_req) begin
            uflow_d = 1'b1;
          end
          if (redir && (tgt[1:0] != 2'b00)) begin
            pc_d  = EXC_VEC;
            mis_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      mis_q   <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      uflow_q <= uflow_d;
    end
  end

  assign PC_OUT    = pc_q;
  assign PC_VALID  = (state_q == S_RUN);
  assign MISALIGN  = mis_q;
  assign RAS_EMPTY = rs_empty;
  assign RAS_UFLOW = uflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus random traffic against a queue-based model.
// Follows PC_RAS_EN the same way the design does.
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam logic [31:0] EXC = 32'h80;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL, HALT, RESUME, BR_TAKE, JMP_TAKE, CALL, RET;
  logic [31:0] BR_OFF, JMP_TGT;
  logic [31:0] PC_OUT;
  logic        PC_VALID, MISALIGN, RAS_EMPTY, RAS_UFLOW;

  pc_unit #(
    .WIDTH(32), .STEP(4), .RESET_VEC(32'h0),
    .EXC_VEC(32'h80), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .HALT(HALT), .RESUME(RESUME),
    .BR_TAKE(BR_TAKE), .BR_OFF(BR_OFF),
    .JMP_TAKE(JMP_TAKE), .JMP_TGT(JMP_TGT),
    .CALL(CALL), .RET(RET),
    .PC_OUT(PC_OUT), .PC_VALID(PC_VALID),
    .MISALIGN(MISALIGN), .RAS_EMPTY(RAS_EMPTY),
    .RAS_UFLOW(RAS_UFLOW)
  );

  always #5 CLK = ~CLK;

  int npass = 0;
  int ntotal = 0;

  // Reference model: 0 = boot, 1 = running, 2 = halted
  logic [31:0] m_pc;
  int          m_st;
  bit          m_mis, m_uf;
  logic [31:0] stk [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_st  = 0;
    m_mis = 1'b0;
    m_uf  = 1'b0;
    stk.delete();
  endtask

  task automatic model_edge();
    logic [31:0] t;
    bit          jumpy;
    m_mis = 1'b0;
    m_uf  = 1'b0;
    if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 2) begin
      if (RESUME) m_st = 1;
    end else if (HALT) begin
      m_st = 2;
    end else if (!STALL) begin
      jumpy = 1'b1;
      if (JMP_TAKE) begin
        t = JMP_TGT;
        if (RAS && CALL) begin
          if (stk.size() == DEPTH) void'(stk.pop_front());
          stk.push_back(m_pc + 32'd4);
        end
      end else if (BR_TAKE) begin
        t = m_pc + BR_OFF;
      end else if (RAS && RET && stk.size() > 0) begin
        t = stk.pop_back();
      end else begin
        if (RAS && RET) m_uf = 1'b1;
        t = m_pc + 32'd4;
        jumpy = 1'b0;
      end
      if (jumpy && (t % 4 != 0)) begin
        m_pc  = EXC;
        m_mis = 1'b1;
      end else begin
        m_pc = t;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"},    PC_OUT,           m_pc);
    chk({tag, ".valid"}, 32'(PC_VALID),    32'(m_st == 1));
    chk({tag, ".mis"},   32'(MISALIGN),    32'(m_mis));
    chk({tag, ".empty"}, 32'(RAS_EMPTY),   32'(stk.size() == 0));
    chk({tag, ".uflow"}, 32'(RAS_UFLOW),   32'(m_uf));
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    STALL = 0; HALT = 0; RESUME = 0;
    BR_TAKE = 0; JMP_TAKE = 0; CALL = 0; RET = 0;
    BR_OFF = '0; JMP_TGT = '0;
  endtask

  task automatic jump(logic [31:0] a, string tag);
    idle();
    JMP_TAKE = 1; JMP_TGT = a;
    step(tag);
  endtask

  initial begin
    idle();
    RESET = 0;
    model_reset();
    #12;
    check_all("rst");
    chk("t1.pc0", PC_OUT, 32'h0);
    RESET = 1;
    step("t1a");
    chk("t1.pc1", PC_OUT, 32'h0);
    chk("t1.v1", 32'(PC_VALID), 32'h1);
    step("t1b");
    chk("t1.pc2", PC_OUT, 32'h4);

    // Branch backwards, then jump beats branch
    jump(32'h10, "t2j");
    idle(); BR_TAKE = 1; BR_OFF = -32'sd8;
    step("t2b");
    chk("t2.br", PC_OUT, 32'h8);
    JMP_TAKE = 1; JMP_TGT = 32'h100;
    step("t2jb");
    chk("t2.jwin", PC_OUT, 32'h100);

    // Stall, halt, resume
    jump(32'h20, "t3j");
    idle(); STALL = 1;
    for (int i = 0; i < 3; i++) step("t3s");
    chk("t3.stall", PC_OUT, 32'h20);
    STALL = 0; HALT = 1; BR_TAKE = 1; BR_OFF = 32'h40;
    step("t3h");
    chk("t3.hv", 32'(PC_VALID), 32'h0);
    idle(); HALT = 1;
    step("t3hh");
    idle(); RESUME = 1;
    step("t3r");
    chk("t3.rpc", PC_OUT, 32'h20);
    idle();
    step("t3n");
    chk("t3.seq", PC_OUT, 32'h24);

    // Misaligned jump traps; wraparound
    jump(32'h102, "t4m");
    chk("t4.exc", PC_OUT, 32'h80);
    chk("t4.mis", 32'(MISALIGN), 32'h1);
    idle();
    step("t4c");
    chk("t4.mis0", 32'(MISALIGN), 32'h0);
    jump(32'hFFFF_FFFC, "t4w");
    idle();
    step("t4z");
    chk("t4.wrap", PC_OUT, 32'h0);

    // Call/return
    jump(32'h40, "t5j");
    idle(); JMP_TAKE = 1; JMP_TGT = 32'h200; CALL = 1;
    step("t5c");
    chk("t5.call", PC_OUT, 32'h200);
    idle(); RET = 1;
    step("t5r");
`ifdef PC_RAS_EN
    chk("t5.ret", PC_OUT, 32'h44);
    for (int i = 1; i <= 5; i++) begin
      idle(); JMP_TAKE = 1; CALL = 1;
      JMP_TGT = 32'(i) << 12;
      step("t5n");
    end
    chk("t5.full", 32'(RAS_EMPTY), 32'h0);
    for (int i = 4; i >= 1; i--) begin
      idle(); RET = 1;
      step("t5p");
      chk("t5.rtn", PC_OUT, (32'(i) << 12) + 32'h4);
    end
    idle(); RET = 1;
    step("t5u");
    chk("t5.uf", 32'(RAS_UFLOW), 32'h1);
    chk("t5.ufpc", PC_OUT, 32'h1008);
`else
    chk("t5.noret", PC_OUT, 32'h204);
    chk("t5.nouf", 32'(RAS_UFLOW), 32'h0);
`endif
    idle();
    step("t5i");

    // Async reset while a branch is pending
    BR_TAKE = 1; BR_OFF = 32'h100;
    #2;
    RESET = 0;
    model_reset();
    #1;
    chk("t6.pc", PC_OUT, 32'h0);
    chk("t6.empty", 32'(RAS_EMPTY), 32'h1);
    check_all("t6");
    @(negedge CLK);
    idle();
    RESET = 1;
    step("t6b");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      STALL    = ($urandom_range(0, 99) < 10);
      HALT     = ($urandom_range(0, 99) < 5);
      RESUME   = ($urandom_range(0, 99) < 30);
      JMP_TAKE = ($urandom_range(0, 99) < 15);
      BR_TAKE  = ($urandom_range(0, 99) < 15);
      CALL     = ($urandom_range(0, 99) < 50);
      RET      = ($urandom_range(0, 99) < 25);
      JMP_TGT  = $urandom;
      if ($urandom_range(0, 9) != 0) JMP_TGT[1:0] = 2'b00;
      BR_OFF   = 32'($urandom_range(0, 128)) * 4 - 32'd256;
      if ($urandom_range(0, 9) == 0) BR_OFF = BR_OFF + 32'd2;
      step("rnd");
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
